// File: rtl/spi_flash_writer.sv
// spi_flash_writer: drives WREN, sector-erase / page-program and status polling through a byte-level SPI controller.
// Latency: first byte is strobed 1 cycle after cmd_strobe; each later byte 1 cycle after the previous exchange (or payload handshake).
// Backpressure: one payload byte in flight via wr_valid/wr_ready, CS held while starved; poll timeout enabled by SPI_FLASH_POLL_TIMEOUT_EN.
module spi_flash_writer #(
    parameter int GAP_CYCLES = 8,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_strobe,
    input  logic        cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic        spi_enable,
    output logic        spi_tx_strobe,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_tx_ready,
    input  logic        spi_rx_strobe,
    input  logic [7:0]  spi_rx_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_GAP1, S_CMD, S_ADDR, S_DATA, S_GAP2, S_POLL, S_DONE
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
`endif

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [1:0]    addr_cnt_q, addr_cnt_d;
    logic [8:0]    data_cnt_q, data_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          poll_first_q, poll_first_d;
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
    logic [15:0]   poll_cnt_q, poll_cnt_d;
`endif
    logic          spi_enable_q, spi_enable_d;
    logic          tx_strobe_q, tx_strobe_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          wr_ready_q, wr_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    status_q, status_d;

    assign spi_enable    = spi_enable_q;
    assign spi_tx_strobe = tx_strobe_q;
    assign spi_tx_data   = tx_data_q;
    assign wr_ready      = wr_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign status        = status_q;

    // Next-state and next-output logic for the command sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        len_d        = len_q;
        addr_cnt_d   = addr_cnt_q;
        data_cnt_d   = data_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        poll_first_d = poll_first_q;
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
        poll_cnt_d   = poll_cnt_q;
`endif
        spi_enable_d = spi_enable_q;
        tx_strobe_d  = 1'b0;
        tx_data_d    = tx_data_q;
        wr_ready_d   = wr_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        status_d     = status_q;

        case (state_q)
            S_IDLE: begin
                // done_q high means the previous op completes this very cycle; do not restart on it.
                if (cmd_strobe && spi_tx_ready && !done_q) begin
                    op_d         = cmd_op;
                    addr_d       = cmd_addr;
                    len_d        = cmd_len;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    spi_enable_d = 1'b1;
                    tx_strobe_d  = 1'b1;
                    tx_data_d    = 8'h06;
                    state_d      = S_WREN;
                end
            end
            S_WREN: begin
                if (spi_rx_strobe) begin
                    spi_enable_d = 1'b0;
                    gap_cnt_d    = '0;
                    state_d      = S_GAP1;
                end
            end
            S_GAP1, S_GAP2: begin
                if (gap_cnt_q == GAP_LAST) begin
                    spi_enable_d = 1'b1;
                    tx_strobe_d  = 1'b1;
                    if (state_q == S_GAP1) begin
                        tx_data_d = op_q ? 8'h02 : 8'h20;
                        state_d   = S_CMD;
                    end else begin
                        tx_data_d    = 8'h05;
                        poll_first_d = 1'b1;
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
                        poll_cnt_d   = '0;
`endif
                        state_d      = S_POLL;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_CMD: begin
                if (spi_rx_strobe) begin
                    tx_strobe_d = 1'b1;
                    tx_data_d   = addr_q[23:16];
                    addr_cnt_d  = 2'd0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (spi_rx_strobe) begin
                    if (addr_cnt_q == 2'd2) begin
                        if (op_q) begin
                            wr_ready_d = 1'b1;
                            data_cnt_d = '0;
                            state_d    = S_DATA;
                        end else begin
                            spi_enable_d = 1'b0;
                            gap_cnt_d    = '0;
                            state_d      = S_GAP2;
                        end
                    end else begin
                        addr_cnt_d  = addr_cnt_q + 2'd1;
                        tx_strobe_d = 1'b1;
                        tx_data_d   = (addr_cnt_q == 2'd0) ? addr_q[15:8] : addr_q[7:0];
                    end
                end
            end
            S_DATA: begin
                // wr_ready low means a payload byte is in flight on the SPI side.
                if (wr_ready_q) begin
                    if (wr_valid) begin
                        wr_ready_d  = 1'b0;
                        tx_strobe_d = 1'b1;
                        tx_data_d   = wr_data;
                    end
                end else if (spi_rx_strobe) begin
                    data_cnt_d = data_cnt_q + 9'd1;
                    if (data_cnt_q == {1'b0, len_q}) begin
                        spi_enable_d = 1'b0;
                        gap_cnt_d    = '0;
                        state_d      = S_GAP2;
                    end else begin
                        wr_ready_d = 1'b1;
                    end
                end
            end
            S_POLL: begin
                if (spi_rx_strobe) begin
                    if (poll_first_q) begin
                        poll_first_d = 1'b0;
                        tx_strobe_d  = 1'b1;
                        tx_data_d    = 8'h00;
                    end else begin
                        status_d = spi_rx_data;
                        if (!spi_rx_data[0]) begin
                            spi_enable_d = 1'b0;
                            state_d      = S_DONE;
                        end else begin
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
                            if (poll_cnt_q == POLL_LAST) begin
                                spi_enable_d = 1'b0;
                                error_d      = 1'b1;
                                state_d      = S_DONE;
                            end else begin
                                poll_cnt_d  = poll_cnt_q + 16'd1;
                                tx_strobe_d = 1'b1;
                                tx_data_d   = 8'h00;
                            end
`else
                            tx_strobe_d = 1'b1;
                            tx_data_d   = 8'h00;
`endif
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            addr_cnt_q   <= '0;
            data_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            poll_first_q <= 1'b0;
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
            poll_cnt_q   <= '0;
`endif
            spi_enable_q <= 1'b0;
            tx_strobe_q  <= 1'b0;
            tx_data_q    <= '0;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            addr_cnt_q   <= addr_cnt_d;
            data_cnt_q   <= data_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            poll_first_q <= poll_first_d;
`ifdef SPI_FLASH_POLL_TIMEOUT_EN
            poll_cnt_q   <= poll_cnt_d;
`endif
            spi_enable_q <= spi_enable_d;
            tx_strobe_q  <= tx_strobe_d;
            tx_data_q    <= tx_data_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            status_q     <= status_d;
        end
    end

endmodule
